nv_fifo_rwst_256x8_ctl: RTL and testbench



---
 rtl/nv_fifo_rwst_256x8_ctl_pkg.sv | 30 +++
 rtl/nv_ram_rwst_256x8.sv | 34 +++
 rtl/nv_fifo_rwst_256x8_ctl.sv | 82 ++++++++
 tb/tb_nv_fifo_rwst_256x8_ctl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/nv_fifo_rwst_256x8_ctl_pkg.sv
// Shared constants, read-side state encoding and count helper for the
// rwst-RAM backed byte FIFO controller.
package nv_fifo_rwst_256x8_ctl_pkg;

    localparam int NV_FIFO_RWST_DEPTH = 256;
    localparam int NV_FIFO_RWST_AW    = 8;
    localparam int NV_FIFO_RWST_DW    = 8;
    localparam int NV_FIFO_RWST_CW    = 9;

    typedef enum logic {
        RD_EMPTY   = 1'b0,
        RD_PRESENT = 1'b1
    } rd_state_e;

    // Occupancy update: a write and a pop in the same cycle cancel out.
    function automatic logic [NV_FIFO_RWST_CW-1:0] cnt_next(
        input logic [NV_FIFO_RWST_CW-1:0] cnt,
        input logic                       inc,
        input logic                       dec
    );
        logic [NV_FIFO_RWST_CW-1:0] res;
        case ({inc, dec})
            2'b10:   res = cnt + NV_FIFO_RWST_CW'(1);
            2'b01:   res = cnt - NV_FIFO_RWST_CW'(1);
            default: res = cnt;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/nv_ram_rwst_256x8.sv
// 256x8 RAM: synchronous write, read address latched on re, dout follows
// the latched address so it holds while re is low.
module nv_ram_rwst_256x8
    import nv_fifo_rwst_256x8_ctl_pkg::*;
(
    input  logic                       clk,
    input  logic [NV_FIFO_RWST_AW-1:0] ra,
    input  logic                       re,
    output logic [NV_FIFO_RWST_DW-1:0] dout,
    input  logic [NV_FIFO_RWST_AW-1:0] wa,
    input  logic                       we,
    input  logic [NV_FIFO_RWST_DW-1:0] di,
    input  logic [31:0]                pwrbus_ram_pd
);

    logic [NV_FIFO_RWST_DW-1:0] mem [NV_FIFO_RWST_DEPTH];
    logic [NV_FIFO_RWST_AW-1:0] ra_q;
    logic                       unused_pwrbus;

    // Power-control bus has no function in this behavioural array.
    assign unused_pwrbus = ^pwrbus_ram_pd;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wa] <= di;
        end
        if (re) begin
            ra_q <= ra;
        end
    end

    assign dout = mem[ra_q];

endmodule

// File: rtl/nv_fifo_rwst_256x8_ctl.sv
// Valid/ready FIFO controller presenting one nv_ram_rwst_256x8 as a
// 256-entry byte FIFO; the presented entry remains counted until popped.
module nv_fifo_rwst_256x8_ctl
    import nv_fifo_rwst_256x8_ctl_pkg::*;
#(
    parameter int AFULL_LVL = 240
) (
    input  logic                       nvdla_core_clk,
    input  logic                       nvdla_core_rstn,
    input  logic                       wr_pvld,
    output logic                       wr_prdy,
    input  logic [NV_FIFO_RWST_DW-1:0] wr_pd,
    output logic                       wr_afull,
    output logic                       rd_pvld,
    input  logic                       rd_prdy,
    output logic [NV_FIFO_RWST_DW-1:0] rd_pd,
    output logic [NV_FIFO_RWST_CW-1:0] fifo_count,
    input  logic [31:0]                pwrbus_ram_pd
);

    logic [NV_FIFO_RWST_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [NV_FIFO_RWST_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [NV_FIFO_RWST_CW-1:0] cnt_q, cnt_d;
    rd_state_e                  rd_state_q, rd_state_d;

    logic rd_pvld_int;
    logic wr_acc;
    logic pop;
    logic ram_avail;
    logic rd_issue;

    assign wr_prdy    = nvdla_core_rstn & (cnt_q != NV_FIFO_RWST_CW'(NV_FIFO_RWST_DEPTH));
    assign wr_afull   = nvdla_core_rstn & (cnt_q >= NV_FIFO_RWST_CW'(AFULL_LVL));
    assign fifo_count = nvdla_core_rstn ? cnt_q : '0;
    assign rd_pvld    = rd_pvld_int;

    always_comb begin
        rd_pvld_int = (rd_state_q == RD_PRESENT);
        wr_acc      = wr_pvld & wr_prdy;
        pop         = rd_pvld_int & rd_prdy;
        // Entries still in the RAM that have not yet been issued for read.
        ram_avail   = (cnt_q - {{(NV_FIFO_RWST_CW-1){1'b0}}, rd_pvld_int}) != '0;
        rd_issue    = nvdla_core_rstn & ram_avail & (~rd_pvld_int | pop);

        wr_ptr_d   = wr_acc   ? wr_ptr_q + NV_FIFO_RWST_AW'(1) : wr_ptr_q;
        rd_ptr_d   = rd_issue ? rd_ptr_q + NV_FIFO_RWST_AW'(1) : rd_ptr_q;
        cnt_d      = cnt_next(cnt_q, wr_acc, pop);

        rd_state_d = rd_state_q;
        case (rd_state_q)
            RD_EMPTY:   if (rd_issue)        rd_state_d = RD_PRESENT;
            RD_PRESENT: if (pop & ~rd_issue) rd_state_d = RD_EMPTY;
            default:                         rd_state_d = RD_EMPTY;
        endcase
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (!nvdla_core_rstn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            rd_state_q <= RD_EMPTY;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            rd_state_q <= rd_state_d;
        end
    end

    nv_ram_rwst_256x8 u_ram (
        .clk           (nvdla_core_clk),
        .ra            (rd_ptr_q),
        .re            (rd_issue),
        .dout          (rd_pd),
        .wa            (wr_ptr_q),
        .we            (wr_acc),
        .di            (wr_pd),
        .pwrbus_ram_pd (pwrbus_ram_pd)
    );

endmodule

// File: tb/tb_nv_fifo_rwst_256x8_ctl.sv
// Directed testbench for nv_fifo_rwst_256x8_ctl.
module tb_nv_fifo_rwst_256x8_ctl;

    logic       clk;
    logic       rstn;
    logic       wr_pvld;
    logic       wr_prdy;
    logic [7:0] wr_pd;
    logic       wr_afull;
    logic       rd_pvld;
    logic       rd_prdy;
    logic [7:0] rd_pd;
    logic [8:0] fifo_count;
    logic [31:0] pwrbus;

    int n_checks = 0;
    int n_fail   = 0;
    int wr_k     = 0;
    int rd_k     = 0;

    nv_fifo_rwst_256x8_ctl #(.AFULL_LVL(240)) dut (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rstn),
        .wr_pvld         (wr_pvld),
        .wr_prdy         (wr_prdy),
        .wr_pd           (wr_pd),
        .wr_afull        (wr_afull),
        .rd_pvld         (rd_pvld),
        .rd_prdy         (rd_prdy),
        .rd_pd           (rd_pd),
        .fifo_count      (fifo_count),
        .pwrbus_ram_pd   (pwrbus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; wr_pvld = 1'b0; wr_pd = 8'h00; rd_prdy = 1'b0; pwrbus = 32'h0;
        tick(); tick();
        n_checks++; if (fifo_count !== 9'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
        n_checks++; if (wr_prdy !== 1'b0) begin n_fail++; $display("FAIL reset_wr_prdy: got %b expected 0", wr_prdy); end
        n_checks++; if (wr_afull !== 1'b0) begin n_fail++; $display("FAIL reset_afull: got %b expected 0", wr_afull); end
        n_checks++; if (rd_pvld !== 1'b0) begin n_fail++; $display("FAIL reset_rd_pvld: got %b expected 0", rd_pvld); end
        rstn = 1'b1;
        #1;
        n_checks++; if (wr_prdy !== 1'b1) begin n_fail++; $display("FAIL reset_release_wr_prdy: got %b expected 1", wr_prdy); end
    endtask

    task automatic test_single();
        wr_pvld = 1'b1; wr_pd = 8'hA5; rd_prdy = 1'b1;
        tick();
        wr_pvld = 1'b0;
        n_checks++; if (fifo_count !== 9'd1) begin n_fail++; $display("FAIL single_count1: got %0d expected 1", fifo_count); end
        n_checks++; if (rd_pvld !== 1'b0) begin n_fail++; $display("FAIL single_pvld_early: got %b expected 0", rd_pvld); end
        tick();
        n_checks++; if (rd_pvld !== 1'b1) begin n_fail++; $display("FAIL single_pvld: got %b expected 1", rd_pvld); end
        n_checks++; if (rd_pd !== 8'hA5) begin n_fail++; $display("FAIL single_data: got %0h expected a5", rd_pd); end
        tick();
        n_checks++; if (fifo_count !== 9'd0) begin n_fail++; $display("FAIL single_count0: got %0d expected 0", fifo_count); end
        n_checks++; if (rd_pvld !== 1'b0) begin n_fail++; $display("FAIL single_pvld_drop: got %b expected 0", rd_pvld); end
    endtask

    task automatic test_fill();
        rd_prdy = 1'b0;
        for (int i = 0; i < 256; i++) begin
            n_checks++; if (wr_prdy !== 1'b1) begin n_fail++; $display("FAIL fill_wr_prdy[%0d]: got %b expected 1", i, wr_prdy); end
            wr_pvld = 1'b1; wr_pd = 8'(i);
            tick();
            n_checks++; if (fifo_count !== 9'(i + 1)) begin n_fail++; $display("FAIL fill_count[%0d]: got %0d expected %0d", i, fifo_count, i + 1); end
            n_checks++; if (wr_afull !== ((i + 1) >= 240)) begin n_fail++; $display("FAIL fill_afull[%0d]: got %b expected %b", i, wr_afull, ((i + 1) >= 240)); end
        end
        wr_k = 256;
        n_checks++; if (wr_prdy !== 1'b0) begin n_fail++; $display("FAIL full_wr_prdy: got %b expected 0", wr_prdy); end
        wr_pd = 8'hEE;
        tick();
        wr_pvld = 1'b0;
        n_checks++; if (fifo_count !== 9'd256) begin n_fail++; $display("FAIL full_overflow_count: got %0d expected 256", fifo_count); end
        n_checks++; if (rd_pvld !== 1'b1 || rd_pd !== 8'h00) begin n_fail++; $display("FAIL full_head: got pvld=%b pd=%0h expected pvld=1 pd=0", rd_pvld, rd_pd); end
    endtask

    task automatic test_stream();
        logic wacc, popn;
        rd_prdy = 1'b1; wr_pvld = 1'b1;
        for (int cyc = 0; cyc < 512; cyc++) begin
            wr_pd = wr_k[7:0];
            wacc = wr_prdy;
            popn = rd_pvld;
            if (popn) begin
                n_checks++; if (rd_pd !== rd_k[7:0]) begin n_fail++; $display("FAIL stream_data[%0d]: got %0h expected %0h", rd_k, rd_pd, rd_k[7:0]); end
            end
            if (cyc >= 1) begin
                n_checks++; if (rd_pvld !== 1'b1 || fifo_count !== 9'd255) begin n_fail++; $display("FAIL stream_steady[%0d]: got pvld=%b count=%0d expected pvld=1 count=255", cyc, rd_pvld, fifo_count); end
            end
            tick();
            if (wacc) wr_k++;
            if (popn) rd_k++;
        end
        wr_pvld = 1'b0;
        for (int g = 0; g < 600; g++) begin
            if (!rd_pvld) break;
            n_checks++; if (rd_pd !== rd_k[7:0]) begin n_fail++; $display("FAIL drain_data[%0d]: got %0h expected %0h", rd_k, rd_pd, rd_k[7:0]); end
            tick();
            rd_k++;
        end
        n_checks++; if (rd_k != 767 || wr_k != 767) begin n_fail++; $display("FAIL stream_totals: got rd=%0d wr=%0d expected 767 767", rd_k, wr_k); end
        n_checks++; if (fifo_count !== 9'd0) begin n_fail++; $display("FAIL stream_empty: got %0d expected 0", fifo_count); end
    endtask

    task automatic test_cnt1();
        rd_prdy = 1'b0; wr_pvld = 1'b1; wr_pd = 8'h11;
        tick();
        wr_pvld = 1'b0;
        tick();
        n_checks++; if (rd_pvld !== 1'b1 || rd_pd !== 8'h11 || fifo_count !== 9'd1) begin n_fail++; $display("FAIL cnt1_setup: got pvld=%b pd=%0h count=%0d expected 1 11 1", rd_pvld, rd_pd, fifo_count); end
        wr_pvld = 1'b1; wr_pd = 8'h3C; rd_prdy = 1'b1;
        tick();
        wr_pvld = 1'b0;
        n_checks++; if (fifo_count !== 9'd1) begin n_fail++; $display("FAIL cnt1_count: got %0d expected 1", fifo_count); end
        n_checks++; if (rd_pvld !== 1'b0) begin n_fail++; $display("FAIL cnt1_bubble: got %b expected 0", rd_pvld); end
        tick();
        n_checks++; if (rd_pvld !== 1'b1 || rd_pd !== 8'h3C) begin n_fail++; $display("FAIL cnt1_next: got pvld=%b pd=%0h expected 1 3c", rd_pvld, rd_pd); end
        tick();
        n_checks++; if (fifo_count !== 9'd0 || rd_pvld !== 1'b0) begin n_fail++; $display("FAIL cnt1_empty: got count=%0d pvld=%b expected 0 0", fifo_count, rd_pvld); end
    endtask

    task automatic test_stall();
        int n;
        rd_prdy = 1'b0; wr_pvld = 1'b1; wr_pd = 8'h40;
        tick();
        wr_pvld = 1'b0;
        tick();
        for (int c = 0; c < 20; c++) begin
            n_checks++; if (rd_pvld !== 1'b1 || rd_pd !== 8'h40) begin n_fail++; $display("FAIL stall_hold[%0d]: got pvld=%b pd=%0h expected 1 40", c, rd_pvld, rd_pd); end
            if (c < 10) begin wr_pvld = 1'b1; wr_pd = 8'(8'h41 + c); end
            else wr_pvld = 1'b0;
            tick();
        end
        wr_pvld = 1'b0;
        n_checks++; if (fifo_count !== 9'd11) begin n_fail++; $display("FAIL stall_count: got %0d expected 11", fifo_count); end
        rd_prdy = 1'b1;
        n = 0;
        for (int g = 0; g < 40; g++) begin
            if (rd_pvld) begin
                n_checks++; if (rd_pd !== 8'(8'h40 + n)) begin n_fail++; $display("FAIL stall_order[%0d]: got %0h expected %0h", n, rd_pd, 8'h40 + n); end
                n++;
            end
            tick();
        end
        n_checks++; if (n != 11) begin n_fail++; $display("FAIL stall_total: got %0d expected 11", n); end
    endtask

    task automatic test_reset_mid();
        rd_prdy = 1'b0;
        for (int i = 0; i < 100; i++) begin
            wr_pvld = 1'b1; wr_pd = 8'(i + 1);
            tick();
        end
        wr_pvld = 1'b0;
        n_checks++; if (fifo_count !== 9'd100) begin n_fail++; $display("FAIL mid_count: got %0d expected 100", fifo_count); end
        rstn = 1'b0;
        tick();
        n_checks++; if (rd_pvld !== 1'b0 || fifo_count !== 9'd0 || wr_prdy !== 1'b0) begin n_fail++; $display("FAIL mid_reset: got pvld=%b count=%0d prdy=%b expected 0 0 0", rd_pvld, fifo_count, wr_prdy); end
        rstn = 1'b1;
        #1;
        n_checks++; if (wr_prdy !== 1'b1 || fifo_count !== 9'd0) begin n_fail++; $display("FAIL mid_release: got prdy=%b count=%0d expected 1 0", wr_prdy, fifo_count); end
        wr_pvld = 1'b1; wr_pd = 8'h5A; rd_prdy = 1'b1;
        tick();
        wr_pvld = 1'b0;
        tick();
        n_checks++; if (rd_pvld !== 1'b1 || rd_pd !== 8'h5A) begin n_fail++; $display("FAIL mid_roundtrip: got pvld=%b pd=%0h expected 1 5a", rd_pvld, rd_pd); end
        tick();
        n_checks++; if (fifo_count !== 9'd0 || rd_pvld !== 1'b0) begin n_fail++; $display("FAIL mid_final: got count=%0d pvld=%b expected 0 0", fifo_count, rd_pvld); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_stream();
        test_cnt1();
        test_stall();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
